// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction fetch stage.
//   fq_entry_t : one prefetch queue entry {pc, instr}
//   NOP_INSTR  : value driven on the head instruction when the queue is empty
//   clog2      : ceiling log2, usable in parameter expressions
package if_pkg;

    localparam int unsigned IF_XLEN = 32;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] instr;
    } fq_entry_t;

    localparam logic [IF_XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = 32'(i + 1);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between the PC/imem and decode.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : synchronous clear, same effect as reset
//   push, pop     : enqueue wdata / dequeue head (pop ignored when empty,
//                   push ignored when full unless popping in the same cycle)
//   wdata, rdata  : entry written at the tail / head entry (zero when empty)
//   count         : occupancy; full/empty derived from it
module fetch_fifo
    import if_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  type         T     = fq_entry_t,
    localparam int unsigned PW    = clog2(DEPTH),
    localparam int unsigned CW    = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  T              wdata,
    output T              rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    T              mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign do_pop_s  = pop & ~empty;
    // A full queue can still accept a push when the head leaves this cycle.
    assign do_push_s = push & (~full | do_pop_s);

    // Next pointer and occupancy; flush returns everything to the empty state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush && !rst) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Head entry, forced to zero when nothing is queued.
    always_comb begin
        rdata = '0;
        if (empty) begin
            rdata = '0;
        end else begin
            rdata = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/inst_fetch_q.sv
// Instruction fetch stage with PC register, word-addressed instruction
// memory (loadable through a write port) and a prefetch queue feeding decode
// through a valid/ready handshake. A redirect from EX flushes the queue.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   fetch_en                       : allow new fetches into the queue
//   redir_valid, redir_pc          : branch/jump redirect from EX
//   imem_we, imem_waddr, imem_wdata: instruction memory load port (byte addr)
//   id_ready                       : decode takes the head entry
//   if_valid, if_instr, if_pc, if_pc4 : head entry toward decode
//   fq_count                       : queue occupancy
module inst_fetch_q
    import if_pkg::*;
#(
    parameter  int unsigned      XLEN       = 32,
    parameter  int unsigned      IMEM_DEPTH = 1024,
    parameter  int unsigned      FQ_DEPTH   = 4,
    parameter  logic [XLEN-1:0]  RESET_PC   = 32'h0000_0000,
    localparam int unsigned      AW         = clog2(IMEM_DEPTH),
    localparam int unsigned      CW         = clog2(FQ_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    input  logic            imem_we,
    input  logic [XLEN-1:0] imem_waddr,
    input  logic [XLEN-1:0] imem_wdata,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4,
    output logic [CW-1:0]   fq_count
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    logic [XLEN-1:0] imem [IMEM_DEPTH];
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   fetch_idx_s;
    logic [AW-1:0]   wr_idx_s;
    logic            push_s;
    logic            pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    entry_t          wentry_s;
    entry_t          head_s;
    logic            unused_addr_bits_s;

    // Upper address bits wrap away; low two bits are always word-aligned.
    assign fetch_idx_s        = fetch_pc_q[AW+1:2];
    assign wr_idx_s           = imem_waddr[AW+1:2];
    assign unused_addr_bits_s = ^{imem_waddr[XLEN-1:AW+2], imem_waddr[1:0],
                                  fetch_pc_q[XLEN-1:AW+2], fetch_pc_q[1:0],
                                  redir_pc[1:0]};

    // A redirect cancels both the pop and the push of its cycle.
    assign pop_s  = ~fifo_empty_s & id_ready & ~redir_valid;
    assign push_s = fetch_en & ~redir_valid & (~fifo_full_s | pop_s);

    // Combinational read sees the pre-write word on a same-index collision.
    assign wentry_s.pc    = fetch_pc_q;
    assign wentry_s.instr = imem[fetch_idx_s];

    // Instruction memory load port; untouched by reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[wr_idx_s] <= imem_wdata;
        end
    end

    // Next fetch PC: redirect target (aligned) beats sequential advance.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redir_valid) begin
            fetch_pc_d = {redir_pc[XLEN-1:2], 2'b00};
        end else if (push_s) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redir_valid),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wentry_s),
        .rdata (head_s),
        .count (fq_count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Head outputs toward decode; all fields read zero while empty.
    always_comb begin
        if_valid = 1'b0;
        if_pc    = '0;
        if_instr = XLEN'(NOP_INSTR);
        if_pc4   = '0;
        if (fifo_empty_s) begin
            if_valid = 1'b0;
            if_pc    = '0;
            if_instr = XLEN'(NOP_INSTR);
            if_pc4   = '0;
        end else begin
            if_valid = 1'b1;
            if_pc    = head_s.pc;
            if_instr = head_s.instr;
            if_pc4   = head_s.pc + PC_STEP;
        end
    end

endmodule
